segment_scan_controller: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode/cathode 7-segment digits that share one segment_decoder.
- Cycles through the digits one at a time:
  - selects one nibble from a shadow register and drives it through the decoder;
  - enables exactly one digit strobe per slot;
  - inserts a dead-time blank between digits to suppress ghosting.
- New display values are accepted through a load/ready handshake and applied only at frame boundaries, so a frame never shows a torn value.

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/segment_decoder.sv | 32 +++
 rtl/segment_scan_controller.sv | 111 +++++++++++
 tb/tb_segment_scan_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF    = 8'h00;
    localparam int         MAX_DIGITS = 8;

    // All strobes released; callers slice this down to their digit count.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/segment_decoder.sv
// Hex nibble to 7-segment pattern, bit order {dp,g,f,e,d,c,b,a}, active-high.
module segment_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] d,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (d)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/segment_scan_controller.sv
// Time-multiplexed digit scanner with dead-time blanking, frame-aligned
// display updates through a load/ready handshake, and leading-zero blanking.
module segment_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    lz_en,
    output logic                    ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_v;

    logic                    slot_end;
    logic                    wrap;
    logic [3:0]              nibble;
    logic [7:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;

    assign ready    = ~pend_v;
    assign slot_end = (state == DRIVE) && (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign nibble   = shadow[{idx, 2'b00} +: 4];

    segment_decoder u_decoder (
        .d   (nibble),
        .seg (dec_seg)
    );

    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (shadow[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            an         <= AN_OFF[NUM_DIGITS-1:0];
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            frame_tick <= wrap;

            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state <= BLANK;
                        idx   <= wrap ? '0 : idx + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase

            // A load accepted on the wrap edge lands in pending only, so it
            // waits a full frame before reaching the shadow register.
            if (wrap && pend_v) begin
                shadow <= pending;
                pend_v <= 1'b0;
            end else if (load && ready) begin
                pending <= data;
                pend_v  <= 1'b1;
            end

            if ((state == DRIVE) && !(lz_en && lz_mask[idx])) begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= dec_seg;
            end else begin
                an  <= AN_OFF[NUM_DIGITS-1:0];
                seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_controller.sv
// Scoreboard bench: stimulus queues the expected digit windows of each frame,
// a monitor pops one entry per observed drive window and checks invariants.
module tb_segment_scan_controller;

    localparam int ND     = 4;
    localparam int PS     = 8;
    localparam int BC     = 2;
    localparam int FRAME  = ND * PS;
    localparam int DRIVE_LEN = PS - BC;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        int         gap;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          load;
    logic [15:0]   data;
    logic          lz_en;
    logic          ready;
    logic [3:0]    an;
    logic [7:0]    seg;
    logic          frame_tick;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    bit   mon_en;
    int   last_drv;

    segment_scan_controller #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .lz_en      (lz_en),
        .ready      (ready),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;
            4'h1: return 8'h06;
            4'h2: return 8'h5B;
            4'h3: return 8'h4F;
            4'h4: return 8'h66;
            4'h5: return 8'h6D;
            4'h6: return 8'h7D;
            4'h7: return 8'h07;
            4'h8: return 8'h7F;
            4'h9: return 8'h6F;
            4'hA: return 8'h77;
            4'hB: return 8'h7C;
            4'hC: return 8'h39;
            4'hD: return 8'h5E;
            4'hE: return 8'h79;
            default: return 8'h71;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One-cycle load pulse from a negedge; ready must read low afterwards
    // whether the load was taken or ignored.
    task automatic applyStimulus(input logic [15:0] d);
        load = 1'b1;
        data = d;
        @(posedge clk);
        #1;
        checkOutput("ready_after_load", ready, 0);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitTick(input string name);
        int n;
        for (n = 0; n < 4 * FRAME; n++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        if (n >= 4 * FRAME) checkOutput(name, 0, 1);
    endtask

    task automatic startMonitor();
        last_drv = -1;
        mon_en   = 1'b1;
    endtask

    task automatic pushFrame(input logic [15:0] d, input bit lz);
        exp_t e;
        int   steps;
        for (int i = 0; i < ND; i++) begin
            if (lz && i >= 1 && ((d >> (4 * i)) == 16'h0)) continue;
            e.an  = ~(4'b0001 << i);
            e.seg = seg_of(d[4*i +: 4]);
            if (last_drv < 0) begin
                e.gap = -1;
            end else begin
                steps = (i - last_drv + ND) % ND;
                if (steps == 0) steps = ND;
                e.gap = BC + PS * (steps - 1);
            end
            exp_q.push_back(e);
            last_drv = i;
        end
    endtask

    initial begin : monitor
        int         cyc;
        int         last_tick;
        bit         in_win;
        bit         win_chk;
        bit         win_stable;
        logic [3:0] win_an;
        logic [7:0] win_seg;
        int         win_len;
        int         win_gap;
        int         gap_cnt;
        exp_t       e;
        cyc = 0; last_tick = -1; in_win = 0; gap_cnt = 0;
        win_chk = 0; win_stable = 1; win_an = '1; win_seg = '0; win_len = 0; win_gap = 0;
        forever begin
            @(negedge clk);
            cyc++;
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("[TB] FAIL onehot: an=%b, expected at most one low bit", an);
            end
            checks++;
            if (an == 4'hF && seg != 8'h00) begin
                errors++;
                $display("[TB] FAIL blank_seg: seg=%h with an=1111, expected 00", seg);
            end
            if (rst) begin
                in_win = 0; gap_cnt = 0; last_tick = -1;
            end else begin
                if (frame_tick) begin
                    if (mon_en && last_tick >= 0) begin
                        checks++;
                        if (cyc - last_tick != FRAME) begin
                            errors++;
                            $display("[TB] FAIL tick_period: got %0d, expected %0d", cyc - last_tick, FRAME);
                        end
                    end
                    last_tick = cyc;
                end
                if (an != 4'hF) begin
                    if (!in_win) begin
                        in_win = 1; win_chk = mon_en; win_an = an; win_seg = seg;
                        win_len = 1; win_gap = gap_cnt; win_stable = 1;
                    end else begin
                        win_len++;
                        if (an != win_an || seg != win_seg) win_stable = 0;
                    end
                end else begin
                    if (in_win) begin
                        in_win = 0;
                        gap_cnt = 0;
                        if (win_chk) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("[TB] FAIL window: unexpected an=%b seg=%h, expected none", win_an, win_seg);
                            end else begin
                                e = exp_q.pop_front();
                                if (win_an != e.an || win_seg != e.seg || win_len != DRIVE_LEN || !win_stable
                                    || (e.gap >= 0 && win_gap != e.gap)) begin
                                    errors++;
                                    $display("[TB] FAIL window: an=%b seg=%h len=%0d gap=%0d stable=%0d, expected an=%b seg=%h len=%0d gap=%0d",
                                             win_an, win_seg, win_len, win_gap, win_stable, e.an, e.seg, DRIVE_LEN, e.gap);
                                end
                            end
                        end
                    end
                    gap_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1; load = 1'b0; data = '0; lz_en = 1'b0; mon_en = 1'b0; last_drv = -1;
        checks = 0; errors = 0;

        // Reset state, then async reset in the middle of digit 2 with a pending value.
        repeat (3) @(negedge clk);
        checkOutput("reset_an", an, 4'hF);
        checkOutput("reset_seg", seg, 8'h00);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_tick", frame_tick, 0);
        #1 rst = 1'b0;
        applyStimulus(16'h1234);
        for (n = 0; n < 4 * FRAME; n++) begin
            @(negedge clk);
            if (an == 4'b1011) break;
        end
        checkOutput("reach_digit2", an, 4'b1011);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_an", an, 4'hF);
        checkOutput("async_seg", seg, 8'h00);
        checkOutput("async_ready", ready, 1);
        checkOutput("async_tick", frame_tick, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (an != 4'hF) break;
        end
        checkOutput("first_drive_latency", n, 3);
        checkOutput("first_drive_an", an, 4'hE);
        checkOutput("first_drive_seg", seg, 8'h3F);
        checkOutput("ready_after_reset", ready, 1);

        // Scan order: discarded pending must not show; 1234 appears one frame after load.
        waitTick("tick_timeout_r1");
        startMonitor();
        pushFrame(16'h0000, 1'b0);
        applyStimulus(16'h1234);
        waitTick("tick_timeout_r2");
        checkOutput("ready_at_apply", ready, 1);
        pushFrame(16'h1234, 1'b0);
        waitTick("tick_timeout_r3");
        pushFrame(16'h1234, 1'b0);
        waitTick("tick_timeout_r4");
        mon_en = 1'b0;

        // Handshake: second load while busy is dropped.
        applyStimulus(16'hABCD);
        applyStimulus(16'h5555);
        waitTick("tick_timeout_h1");
        checkOutput("ready_with_tick", ready, 1);
        startMonitor();
        pushFrame(16'hABCD, 1'b0);
        waitTick("tick_timeout_h2");
        mon_en = 1'b0;
        checkOutput("ready_no_5555", ready, 1);

        // Load landing exactly on the wrap edge waits one whole frame.
        repeat (FRAME - 1) @(posedge clk);
        @(negedge clk);
        load = 1'b1;
        data = 16'h8765;
        @(posedge clk);
        #1;
        checkOutput("wrap_load_tick", frame_tick, 1);
        checkOutput("wrap_load_ready", ready, 0);
        @(negedge clk);
        load = 1'b0;
        startMonitor();
        pushFrame(16'hABCD, 1'b0);
        waitTick("tick_timeout_w1");
        checkOutput("wrap_apply_ready", ready, 1);
        pushFrame(16'h8765, 1'b0);
        waitTick("tick_timeout_w2");
        mon_en = 1'b0;

        // Leading-zero blanking.
        applyStimulus(16'h0070);
        waitTick("tick_timeout_l1");
        lz_en = 1'b1;
        startMonitor();
        pushFrame(16'h0070, 1'b1);
        waitTick("tick_timeout_l2");
        pushFrame(16'h0070, 1'b1);
        waitTick("tick_timeout_l3");
        lz_en = 1'b0;
        pushFrame(16'h0070, 1'b0);
        applyStimulus(16'h0000);
        waitTick("tick_timeout_l4");
        lz_en = 1'b1;
        pushFrame(16'h0000, 1'b1);
        waitTick("tick_timeout_l5");
        pushFrame(16'h0000, 1'b1);
        waitTick("tick_timeout_l6");
        mon_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        // Random soak; the monitor checks the strobe invariants every cycle.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            #1;
            load = ($urandom_range(0, 3) == 0);
            data = 16'($urandom);
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            rst = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b1;
        #1;
        checkOutput("final_reset_an", an, 4'hF);
        checkOutput("final_reset_ready", ready, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
